commit_rob: RTL

COMMIT_ROB -- requirements
Module: commit_rob

---
 rtl/purple_jade_pkg.sv | 38 +++
 rtl/rob_commit_sel.sv | 39 +++
 rtl/commit_rob.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/purple_jade_pkg.sv
// Shared types for the commit ROB.
// ROB_DEBUG_EN adds per-entry PC storage so retiring PCs can be traced.
package purple_jade_pkg;

    localparam int unsigned RobPcW   = 16;
    localparam int unsigned RobPregW = 6;

    typedef struct packed {
        logic [RobPcW-1:0]   pc;
        logic                w_v;
        logic                is_store;
        logic                is_branch;
        logic [RobPregW-1:0] alloc_reg;
        logic [RobPregW-1:0] freed_reg;
    } rob_alloc_t;

    typedef struct packed {
        logic                w_v;
        logic                is_store;
        logic [RobPregW-1:0] alloc_reg;
        logic [RobPregW-1:0] freed_reg;
    } rob_commit_t;

    typedef struct packed {
        logic                valid;
        logic                wb;
        logic                mispredict;
        logic [RobPcW-1:0]   target;
        logic                w_v;
        logic                is_store;
        logic [RobPregW-1:0] alloc_reg;
        logic [RobPregW-1:0] freed_reg;
`ifdef ROB_DEBUG_EN
        logic [RobPcW-1:0]   pc;
`endif
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_sel.sv
// Picks the in-order retire group from the COMMIT_W entries starting at the head.
// The group stops at the first non-ready entry, after a mispredicted entry, or before a 2nd store.
module rob_commit_sel #(
    parameter int unsigned COMMIT_W = 2
) (
    input  logic [COMMIT_W-1:0]                valid_i,
    input  logic [COMMIT_W-1:0]                wb_i,
    input  logic [COMMIT_W-1:0]                mispredict_i,
    input  logic [COMMIT_W-1:0]                store_i,
    output logic [COMMIT_W-1:0]                commit_o,
    output logic [$clog2(COMMIT_W+1)-1:0]      num_o
);

    localparam int unsigned CNT_W = $clog2(COMMIT_W + 1);

    logic open;
    logic store_seen;

    always_comb begin
        commit_o   = '0;
        num_o      = '0;
        open       = 1'b1;
        store_seen = 1'b0;
        for (int k = 0; k < int'(COMMIT_W); k++) begin
            if (open && valid_i[k] && wb_i[k] && !(store_i[k] && store_seen)) begin
                commit_o[k] = 1'b1;
                num_o       = num_o + CNT_W'(1);
                store_seen  = store_seen | store_i[k];
                // A mispredicted entry retires but nothing younger may follow it.
                if (mispredict_i[k]) begin
                    open = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

endmodule

// File: rtl/commit_rob.sv
// Reorder buffer: in-order allocation, out-of-order writeback, multi-lane in-order commit.
// ROB_DEBUG_EN adds commit_pc_o with the PC of each retiring lane.
module commit_rob
    import purple_jade_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned NUM_WB   = 4,
    parameter int unsigned PREG_W   = RobPregW,
    parameter int unsigned PC_W     = RobPcW
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  logic                                   alloc_valid_i,
    input  rob_alloc_t                             alloc_entry_i,
    output logic                                   alloc_ready_o,
    output logic [$clog2(DEPTH)-1:0]               alloc_idx_o,

    input  logic [NUM_WB-1:0]                      wb_valid_i,
    input  logic [NUM_WB-1:0][$clog2(DEPTH)-1:0]   wb_idx_i,
    input  logic [NUM_WB-1:0]                      wb_mispredict_i,
    input  logic [NUM_WB-1:0][PC_W-1:0]            wb_target_i,

    output logic [COMMIT_W-1:0]                    commit_valid_o,
    output rob_commit_t [COMMIT_W-1:0]             commit_entry_o,
`ifdef ROB_DEBUG_EN
    output logic [COMMIT_W-1:0][PC_W-1:0]          commit_pc_o,
`endif
    output logic                                   flush_o,
    output logic [PC_W-1:0]                        redirect_pc_o,
    output logic                                   empty_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(COMMIT_W + 1);

    // Entry payload widths are fixed by the shared package types.
    if (PC_W != RobPcW) begin : gen_pc_w_check
        $error("commit_rob: PC_W must equal RobPcW");
    end
    if (PREG_W != RobPregW) begin : gen_preg_w_check
        $error("commit_rob: PREG_W must equal RobPregW");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_depth_check
        $error("commit_rob: DEPTH must be a power of two, at least 4");
    end
    if ((COMMIT_W < 1) || (COMMIT_W > 4)) begin : gen_commit_w_check
        $error("commit_rob: COMMIT_W must be 1 to 4");
    end

    rob_entry_t       entries_q [DEPTH];
    rob_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count_q, count_d;

    logic [IDX_W-1:0]    lane_idx [COMMIT_W];
    logic [COMMIT_W-1:0] lane_valid;
    logic [COMMIT_W-1:0] lane_wb;
    logic [COMMIT_W-1:0] lane_misp;
    logic [COMMIT_W-1:0] lane_store;
    logic [COMMIT_W-1:0] commit_lanes;
    logic [CNT_W-1:0]    retire_num;

    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic             alloc_fire;
    logic [IDX_W-1:0] tail_idx;

    logic unused_alloc;
`ifdef ROB_DEBUG_EN
    assign unused_alloc = alloc_entry_i.is_branch;
`else
    assign unused_alloc = ^{alloc_entry_i.is_branch, alloc_entry_i.pc};
`endif

    always_comb begin
        for (int k = 0; k < int'(COMMIT_W); k++) begin
            lane_idx[k]   = head_q[IDX_W-1:0] + IDX_W'(k);
            lane_valid[k] = entries_q[lane_idx[k]].valid;
            lane_wb[k]    = entries_q[lane_idx[k]].wb;
            lane_misp[k]  = entries_q[lane_idx[k]].mispredict;
            lane_store[k] = entries_q[lane_idx[k]].is_store;
        end
    end

    rob_commit_sel #(
        .COMMIT_W (COMMIT_W)
    ) u_commit_sel (
        .valid_i      (lane_valid),
        .wb_i         (lane_wb),
        .mispredict_i (lane_misp),
        .store_i      (lane_store),
        .commit_o     (commit_lanes),
        .num_o        (retire_num)
    );

    // Only the last lane of a group can carry a mispredict, so at most one match.
    always_comb begin
        flush       = 1'b0;
        redirect_pc = '0;
        for (int k = 0; k < int'(COMMIT_W); k++) begin
            if (commit_lanes[k] && lane_misp[k]) begin
                flush       = 1'b1;
                redirect_pc = PC_W'(entries_q[lane_idx[k]].target);
            end
        end
    end

    assign tail_idx      = tail_q[IDX_W-1:0];
    assign alloc_ready_o = (count_q < PTR_W'(DEPTH)) & ~flush;
    assign alloc_fire    = alloc_valid_i & alloc_ready_o;
    assign alloc_idx_o   = tail_idx;
    assign empty_o       = (head_q == tail_q);
    assign flush_o       = flush;
    assign redirect_pc_o = redirect_pc;

    always_comb begin
        commit_valid_o = commit_lanes;
        commit_entry_o = '0;
`ifdef ROB_DEBUG_EN
        commit_pc_o    = '0;
`endif
        for (int k = 0; k < int'(COMMIT_W); k++) begin
            if (commit_lanes[k]) begin
                commit_entry_o[k].w_v       = entries_q[lane_idx[k]].w_v;
                commit_entry_o[k].is_store  = entries_q[lane_idx[k]].is_store;
                commit_entry_o[k].alloc_reg = entries_q[lane_idx[k]].alloc_reg;
                commit_entry_o[k].freed_reg = entries_q[lane_idx[k]].freed_reg;
`ifdef ROB_DEBUG_EN
                commit_pc_o[k]              = PC_W'(entries_q[lane_idx[k]].pc);
`endif
            end
        end
    end

    always_comb begin
        logic        wb_hit;
        int unsigned wb_sel;

        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_d[i] = entries_q[i];
        end
        head_d  = head_q + PTR_W'(retire_num);
        tail_d  = tail_q;
        count_d = count_q - PTR_W'(retire_num);

        // Scan ports high to low so the lowest-numbered hit wins.
        for (int i = 0; i < int'(DEPTH); i++) begin
            wb_hit = 1'b0;
            wb_sel = 0;
            for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_idx_i[p] == IDX_W'(i))) begin
                    wb_hit = 1'b1;
                    wb_sel = p;
                end
            end
            if (wb_hit && entries_q[i].valid && !entries_q[i].wb) begin
                entries_d[i].wb         = 1'b1;
                entries_d[i].mispredict = wb_mispredict_i[wb_sel];
                entries_d[i].target     = RobPcW'(wb_target_i[wb_sel]);
            end
        end

        for (int k = 0; k < int'(COMMIT_W); k++) begin
            if (commit_lanes[k]) begin
                entries_d[lane_idx[k]].valid = 1'b0;
                entries_d[lane_idx[k]].wb    = 1'b0;
            end
        end

        if (alloc_fire) begin
            entries_d[tail_idx]           = '0;
            entries_d[tail_idx].valid     = 1'b1;
            entries_d[tail_idx].w_v       = alloc_entry_i.w_v;
            entries_d[tail_idx].is_store  = alloc_entry_i.is_store;
            entries_d[tail_idx].alloc_reg = alloc_entry_i.alloc_reg;
            entries_d[tail_idx].freed_reg = alloc_entry_i.freed_reg;
`ifdef ROB_DEBUG_EN
            entries_d[tail_idx].pc        = alloc_entry_i.pc;
`endif
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_d + PTR_W'(1);
        end

        // Flush discards everything younger than the retired group, including writebacks.
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_d[i] = '0;
            end
            tail_d  = head_d;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
